// File: rtl/dma_data_fifo.sv
// dma_data_fifo
// Synchronous first-word-fall-through FIFO sitting between the DMA receiver
// (push side) and the DMA transmitter (pop side). Each entry carries a data
// word, its byte enables and the end-of-transfer flag.
//
// Parameters
//   DataW        payload width in bits (multiple of 8)
//   Depth        number of entries, power of two, >= 2
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset (pointers and count only)
//   flush_i      synchronous discard of every entry; masks push and pop
//   push_valid_i / push_ready_o            push handshake
//   push_data_i / push_be_i / push_last_i  entry payload
//   pop_valid_o / pop_ready_i              pop handshake
//   pop_data_o / pop_be_o / pop_last_o     head entry payload (FWFT)
//   count_o      number of stored entries
//   empty_o      count_o == 0
//   full_o       count_o == Depth
module dma_data_fifo #(
    parameter int DataW = 32,
    parameter int Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    input  logic [DataW-1:0]           push_data_i,
    input  logic [DataW/8-1:0]         push_be_i,
    input  logic                       push_last_i,
    output logic                       push_ready_o,
    output logic                       pop_valid_o,
    output logic [DataW-1:0]           pop_data_o,
    output logic [DataW/8-1:0]         pop_be_o,
    output logic                       pop_last_o,
    input  logic                       pop_ready_i,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam int BeW  = DataW / 8;
    localparam int EntW = DataW + BeW + 1;

    logic [EntW-1:0] mem_q [Depth];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic full, empty;
    logic push_fire, pop_fire;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(Depth));

    // Handshakes depend only on registered occupancy: no push-through when
    // full and no bypass when empty.
    assign push_fire = push_valid_i && !full  && !flush_i;
    assign pop_fire  = pop_ready_i  && !empty && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so the pointers wrap naturally.
            if (push_fire) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked purely by count_q.
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= {push_data_i, push_be_i, push_last_i};
        end
    end

    assign {pop_data_o, pop_be_o, pop_last_o} = mem_q[rd_ptr_q];

    assign push_ready_o = !full;
    assign pop_valid_o  = !empty;
    assign count_o      = count_q;
    assign empty_o      = empty;
    assign full_o       = full;

endmodule

// File: tb/tb_dma_data_fifo.sv
module tb_dma_data_fifo;

    localparam int DataW = 32;
    localparam int Depth = 8;
    localparam int CntW  = $clog2(Depth) + 1;

    typedef struct packed {
        logic [DataW-1:0]   d;
        logic [DataW/8-1:0] b;
        logic               l;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic pv = 1'b0;
    logic [DataW-1:0] pd = '0;
    logic [DataW/8-1:0] pb = '0;
    logic pl = 1'b0;
    logic pr = 1'b0;

    logic push_ready, pop_valid, pop_last, empty, full;
    logic [DataW-1:0] pop_data;
    logic [DataW/8-1:0] pop_be;
    logic [CntW-1:0] count;

    dma_data_fifo #(.DataW(DataW), .Depth(Depth)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .push_valid_i (pv),
        .push_data_i  (pd),
        .push_be_i    (pb),
        .push_last_i  (pl),
        .push_ready_o (push_ready),
        .pop_valid_o  (pop_valid),
        .pop_data_o   (pop_data),
        .pop_be_o     (pop_be),
        .pop_last_o   (pop_last),
        .pop_ready_i  (pr),
        .count_o      (count),
        .empty_o      (empty),
        .full_o       (full)
    );

    always #5 clk = ~clk;

    // Scoreboard: entries the FIFO is expected to hold, oldest first.
    ent_t sb[$];
    bit   pend_push = 1'b0;   // entry queued this cycle, lands at next edge
    int   total = 0;
    int   bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for the current cycle; record an accepted push.
    task automatic drive(bit v, ent_t e, bit r, bit f);
        pv = v; pd = e.d; pb = e.b; pl = e.l; pr = r; flush = f;
        pend_push = v && push_ready && !f && rst_n;
        if (pend_push) sb.push_back(e);
    endtask

    task automatic step(bit v, ent_t e, bit r, bit f);
        @(posedge clk);
        #1;
        drive(v, e, r, f);
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.d = $urandom();
        e.b = 4'($urandom_range(0, 15));
        e.l = 1'($urandom_range(0, 1));
        return e;
    endfunction

    function automatic ent_t mk(logic [DataW-1:0] d, logic l);
        ent_t e;
        e.d = d; e.b = 4'hF; e.l = l;
        return e;
    endfunction

    // Monitor: checks status against the scoreboard, compares the head and
    // retires it on a pop handshake.
    always @(negedge clk) begin
        int exp_cnt;
        ent_t head;
        if (!rst_n) begin
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_empty", 64'(empty), 64'd1);
            chk("rst_full", 64'(full), 64'd0);
            chk("rst_push_ready", 64'(push_ready), 64'd1);
            chk("rst_pop_valid", 64'(pop_valid), 64'd0);
            sb.delete();
        end else begin
            exp_cnt = sb.size() - int'(pend_push);
            chk("count", 64'(count), 64'(exp_cnt));
            chk("empty", 64'(empty), 64'(exp_cnt == 0));
            chk("full", 64'(full), 64'(exp_cnt == Depth));
            chk("push_ready", 64'(push_ready), 64'(exp_cnt != Depth));
            chk("pop_valid", 64'(pop_valid), 64'(exp_cnt != 0));
            if (exp_cnt > 0) begin
                head = sb[0];
                chk("head", 64'({pop_data, pop_be, pop_last}), 64'(head));
            end
            if (flush) sb.delete();
            else if (pop_valid && pr && exp_cnt > 0) void'(sb.pop_front());
        end
        pend_push = 1'b0;
    end

    initial begin
        ent_t z;
        int pv_pct, pr_pct;
        z = '0;

        // Reset, then present the first push as reset releases.
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1, mk(32'hA0, 0), 0, 0);
        step(1, mk(32'hA1, 0), 0, 0);
        step(1, mk(32'hA2, 1), 0, 0);
        step(0, z, 0, 0);
        step(0, z, 0, 0);
        repeat (3) step(0, z, 1, 0);
        step(0, z, 0, 0);

        // Fill past Depth, then one pop frees a slot.
        repeat (Depth + 1) step(1, rnd_ent(), 0, 0);
        step(0, z, 1, 0);
        step(0, z, 0, 0);
        step(0, z, 0, 1);
        step(0, z, 0, 0);

        // Streaming at count=1 across the pointer wrap.
        step(1, rnd_ent(), 0, 0);
        repeat (20) step(1, rnd_ent(), 1, 0);
        step(0, z, 1, 0);
        step(0, z, 0, 0);

        // Push into empty: visible only the cycle after.
        step(1, mk(32'h1234_5678, 1), 0, 0);
        step(0, z, 0, 0);
        step(0, z, 1, 0);
        step(0, z, 0, 0);

        // Flush with concurrent push and pop at count=5.
        repeat (5) step(1, rnd_ent(), 0, 0);
        step(1, rnd_ent(), 1, 1);
        step(0, z, 0, 0);
        step(0, z, 0, 0);

        // Asynchronous reset at count=4, checked before the next edge.
        repeat (4) step(1, rnd_ent(), 0, 0);
        step(0, z, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_empty", 64'(empty), 64'd1);
        chk("async_rst_full", 64'(full), 64'd0);
        chk("async_rst_push_ready", 64'(push_ready), 64'd1);
        chk("async_rst_pop_valid", 64'(pop_valid), 64'd0);
        sb.delete();
        pend_push = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(0, z, 0, 0);

        // Randomized traffic with several occupancy biases.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin pv_pct = 50; pr_pct = 50; end
                1: begin pv_pct = 85; pr_pct = 30; end
                2: begin pv_pct = 30; pr_pct = 85; end
                default: begin pv_pct = 70; pr_pct = 70; end
            endcase
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(0, 99) < pv_pct, rnd_ent(),
                     $urandom_range(0, 99) < pr_pct,
                     $urandom_range(0, 99) < 2);
            end
        end

        step(0, z, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_data_fifo.md
DMA_DATA_FIFO -- requirements
Module: dma_data_fifo

Interface
REQ-001 Parameter DataW, default 32, payload width in bits.
REQ-002 Parameter Depth, default 8, number of entries; SHALL be a power of two, 2 or greater.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 flush_i  input  1  synchronous discard of all entries.
REQ-006 push_valid_i  input  1  receiver offers an entry.
REQ-007 push_data_i  input  DataW  read data from the source.
REQ-008 push_be_i  input  DataW/8  byte enables for the entry.
REQ-009 push_last_i  input  1  marks the final entry of a transfer.
REQ-010 push_ready_o  output  1  FIFO accepts the entry.
REQ-011 pop_valid_o  output  1  head entry is available to the transmitter.
REQ-012 pop_data_o  output  DataW  head payload.
REQ-013 pop_be_o  output  DataW/8  head byte enables.
REQ-014 pop_last_o  output  1  head last flag.
REQ-015 pop_ready_i  input  1  transmitter consumes the head.
REQ-016 count_o  output  $clog2(Depth)+1  number of stored entries.
REQ-017 empty_o  output  1  count_o == 0.
REQ-018 full_o  output  1  count_o == Depth.

Function
REQ-019 The FIFO SHALL operate as a buffer between the DMA receiver and transmitter, storing {data, be, last} per entry in FIFO order.
REQ-020 A push SHALL occur in a cycle where push_valid_i && push_ready_o && !flush_i.
REQ-021 A pop SHALL occur in a cycle where pop_valid_o && pop_ready_i && !flush_i.
REQ-022 push_ready_o SHALL equal !full_o and SHALL NOT depend combinationally on pop_ready_i; there is no push-through when full.
REQ-023 pop_valid_o SHALL equal !empty_o and SHALL NOT depend combinationally on push_valid_i; there is no bypass when empty.
REQ-024 The pop output SHALL be first-word-fall-through: pop_data_o/pop_be_o/pop_last_o show the head entry whenever pop_valid_o is 1.
REQ-025 Latency: an entry pushed at edge N SHALL be visible on pop_* in cycle N+1 when the FIFO was empty.
REQ-026 The pop_* payload outputs SHALL be don't-care while pop_valid_o is 0.
REQ-027 Count update: push only gives +1, pop only gives -1, push and pop together leave count unchanged, neither leaves count unchanged.
REQ-028 Simultaneous push and pop SHALL be legal at any count from 1 to Depth-1; both pointers SHALL advance.
REQ-029 Write and read pointers SHALL wrap from Depth-1 to 0 with no lost or duplicated entry.
REQ-030 flush_i=1 SHALL, at the next edge, set count, write pointer and read pointer to 0, regardless of push and pop.
REQ-031 Any push or pop presented in a flush cycle SHALL be ignored.
REQ-032 A held entry SHALL remain stable on pop_* until popped or flushed; backpressure via pop_ready_i=0 SHALL NOT alter it.
REQ-033 Storage array contents need not be reset; only pointers and count carry reset state.

Reset
REQ-034 While rst_ni=0, the block SHALL hold count_o=0, empty_o=1, full_o=0, push_ready_o=1 and pop_valid_o=0, asynchronously.
REQ-035 Reset asserted mid-operation SHALL discard all entries immediately.
REQ-036 The first push SHALL be accepted on the first rising edge after rst_ni rises.

Verification
REQ-037 Reset then push 0xA0..0xA2 (be=0xF, last on 0xA2) with pop_ready_i=0 -> count_o=3; head=0xA0; pop yields 0xA0, 0xA1, 0xA2 with last=1 only on 0xA2.
REQ-038 Fill to Depth=8 -> full_o=1 and push_ready_o=0; a 9th push_valid_i is not accepted and count stays 8; one pop -> push_ready_o=1 the next cycle.
REQ-039 Hold push and pop every cycle for 20 cycles starting from count=1 -> count stays 1; 20 entries cross the pointer wrap in order.
REQ-040 Push to an empty FIFO at edge N -> pop_valid_o=0 in cycle N and pop_valid_o=1 with correct data in cycle N+1.
REQ-041 With count=5, assert flush_i together with push_valid_i and pop_ready_i -> next cycle count_o=0, empty_o=1, and no entry survives.
REQ-042 Assert rst_ni=0 asynchronously with count=4 -> outputs match REQ-034 before the next clock edge.
